d_cache_ctrl: RTL and testbench

//  Sequencer for the 64x64b byte-enabled D-cache data RAM: direct-mapped, write-back, write-allocate.
//  8 lines x 8 words (64 B/line); tag/valid/dirty kept in flops; RAM addr = {index[2:0], word[2:0]}.

---
 rtl/d_cache_ctrl_pkg.sv | 22 ++
 rtl/d_cache_tag_array.sv | 45 ++++
 rtl/d_cache_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_d_cache_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_ctrl_pkg.sv
// Shared definitions for the D-cache data RAM sequencer: geometry constants and FSM encoding.
package d_cache_ctrl_pkg;

    localparam int LINE_WORDS = 8;
    localparam int NUM_LINES  = 8;
    localparam int INDEX_W    = 3;
    localparam int WORD_W     = 3;
    localparam int OFFSET_W   = 6;
    localparam logic [63:0] ZEROWORD = 64'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_RD,
        S_WB_BEAT,
        S_FILL_REQ,
        S_FILL_DATA,
        S_REPLAY
    } state_t;

endpackage

// File: rtl/d_cache_tag_array.sv
// Per-line tag/valid/dirty storage: combinational lookup, one write port.
module d_cache_tag_array
    import d_cache_ctrl_pkg::*;
#(
    parameter int TAG_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_valid,
    input  logic               wr_dirty
);

    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tags need no reset: they are only trusted while the line is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back, write-allocate D-cache sequencer owning the 64x64b data RAM.
module d_cache_ctrl
    import d_cache_ctrl_pkg::*;
#(
    parameter int PADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [PADDR_W-1:0] cpu_addr_i,
    input  logic [63:0]        cpu_wdata_i,
    input  logic [7:0]         cpu_wstrb_i,
    output logic               cpu_ready_o,
    output logic [63:0]        cpu_rdata_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [PADDR_W-1:0] mem_addr_o,
    input  logic               mem_ack_i,
    output logic [63:0]        mem_wdata_o,
    output logic               mem_wvalid_o,
    input  logic               mem_wready_i,
    input  logic [63:0]        mem_rdata_i,
    input  logic               mem_rvalid_i,
    output logic [5:0]         ram_addr_o,
    output logic [63:0]        ram_wdata_o,
    output logic [7:0]         ram_wena_o,
    input  logic [63:0]        ram_rdata_i,
    output state_t             dbg_state_o
);

    localparam int TAG_W = PADDR_W - INDEX_W - WORD_W - 3;

    state_t               state;
    logic [WORD_W-1:0]    cnt;
    logic                 req_we;
    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_idx;
    logic [WORD_W-1:0]    req_word;
    logic [63:0]          req_wdata;
    logic [7:0]           req_wstrb;

    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic                 hit;
    logic                 store_hit;
    logic                 fill_last;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr_i[2:0];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign store_hit = (state == S_LOOKUP) && hit && req_we;
    assign fill_last = (state == S_FILL_DATA) && mem_rvalid_i && (cnt == WORD_W'(LINE_WORDS - 1));
    assign dbg_state_o = state;

    d_cache_tag_array #(.TAG_W(TAG_W)) u_tags (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .wr_en    (store_hit || fill_last),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_valid (1'b1),
        .wr_dirty (store_hit)
    );

    // RAM address is driven combinationally so the registered RAM read lands in the next state.
    always_comb begin
        cpu_ready_o = 1'b0;
        cpu_rdata_o = ZEROWORD;
        ram_addr_o  = '0;
        ram_wdata_o = ZEROWORD;
        ram_wena_o  = '0;
        mem_wdata_o = ZEROWORD;
        case (state)
            S_IDLE: begin
                if (cpu_req_i) ram_addr_o = {cpu_addr_i[8:6], cpu_addr_i[5:3]};
            end
            S_LOOKUP: begin
                ram_addr_o = {req_idx, req_word};
                if (hit) begin
                    cpu_ready_o = 1'b1;
                    if (req_we) begin
                        ram_wena_o  = req_wstrb;
                        ram_wdata_o = req_wdata;
                    end else begin
                        cpu_rdata_o = ram_rdata_i;
                    end
                end
            end
            S_WB_RD: ram_addr_o = {req_idx, cnt};
            S_WB_BEAT: begin
                ram_addr_o  = {req_idx, cnt};
                mem_wdata_o = ram_rdata_i;
            end
            S_FILL_DATA: begin
                ram_addr_o = {req_idx, cnt};
                if (mem_rvalid_i) begin
                    ram_wena_o  = 8'hFF;
                    ram_wdata_o = mem_rdata_i;
                end
            end
            S_REPLAY: ram_addr_o = {req_idx, req_word};
            default: ;
        endcase
    end

    // Handshakes: mem_req_o holds until the cycle mem_ack_i is seen high; mem_wvalid_o holds with
    // stable data until a cycle with mem_wready_i high; each mem_rvalid_i cycle is one accepted fill beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            req_we       <= 1'b0;
            req_tag      <= '0;
            req_idx      <= '0;
            req_word     <= '0;
            req_wdata    <= ZEROWORD;
            req_wstrb    <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wvalid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        req_we    <= cpu_we_i;
                        req_tag   <= cpu_addr_i[PADDR_W-1:9];
                        req_idx   <= cpu_addr_i[8:6];
                        req_word  <= cpu_addr_i[5:3];
                        req_wdata <= cpu_wdata_i;
                        req_wstrb <= cpu_wstrb_i;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        state <= S_IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= {rd_tag, req_idx, {OFFSET_W{1'b0}}};
                        state      <= S_WB_REQ;
                    end else begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        state      <= S_FILL_REQ;
                    end
                end
                S_WB_REQ, S_FILL_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= '0;
                        cnt        <= '0;
                        state      <= (state == S_WB_REQ) ? S_WB_RD : S_FILL_DATA;
                    end
                end
                S_WB_RD: begin
                    mem_wvalid_o <= 1'b1;
                    state        <= S_WB_BEAT;
                end
                S_WB_BEAT: begin
                    if (mem_wready_i) begin
                        mem_wvalid_o <= 1'b0;
                        if (cnt == WORD_W'(LINE_WORDS - 1)) begin
                            cnt        <= '0;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                            state      <= S_FILL_REQ;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_WB_RD;
                        end
                    end
                end
                S_FILL_DATA: begin
                    if (mem_rvalid_i) begin
                        cnt <= cnt + 1'b1;
                        if (fill_last) state <= S_REPLAY;
                    end
                end
                S_REPLAY: state <= S_LOOKUP;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl: hit vectors from a table, miss/writeback/reset sequences by hand.
module tb_d_cache_ctrl;
    import d_cache_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [7:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [63:0] cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic [5:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wena;
    logic [63:0] ram_rdata;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;
    int wb_beats = 0;

    d_cache_ctrl #(.PADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_wstrb_i  (cpu_wstrb),
        .cpu_ready_o  (cpu_ready),
        .cpu_rdata_o  (cpu_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_wdata_o  (mem_wdata),
        .mem_wvalid_o (mem_wvalid),
        .mem_wready_i (mem_wready),
        .mem_rdata_i  (mem_rdata),
        .mem_rvalid_i (mem_rvalid),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_wena_o   (ram_wena),
        .ram_rdata_i  (ram_rdata),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // byte-enabled data RAM with registered read
    logic [63:0] ram_mem [64];
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            if (ram_wena[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= ram_mem[ram_addr];
    end

    always @(posedge clk) begin
        if (rst && mem_wvalid && mem_wready) wb_beats <= wb_beats + 1;
    end

    // driver tasks
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb, input logic [5:0] exp_ram_addr);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        #1;
        chk("accept_ram_addr", 64'(ram_addr), 64'(exp_ram_addr));
        chk("accept_no_ready", 64'(cpu_ready), 64'd0);
        cyc();
        cpu_req = 1'b0;
    endtask

    task automatic wait_mem_req(input string name, input logic exp_we, input logic [31:0] exp_addr,
                                input logic do_ack);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk({name, "_req_seen"}, 64'(ok), 64'd1);
        chk({name, "_we"}, 64'(mem_we), 64'(exp_we));
        chk({name, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        if (ok && do_ack) begin
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
            #1;
            chk({name, "_req_drop"}, 64'(mem_req), 64'd0);
        end
    endtask

    task automatic fill_line(input logic [2:0] idx, input logic [63:0] add, input logic [63:0] mul,
                             input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            if (i == 4) begin
                mem_rvalid = 1'b0;
                #1;
                chk("fill_gap_wena", 64'(ram_wena), 64'd0);
                cyc();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = add + mul * 64'(i);
            #1;
            chk("fill_wena", 64'(ram_wena), 64'hFF);
            chk("fill_ram_addr", 64'(ram_addr), 64'({idx, 3'(i)}));
            chk("fill_ram_wdata", ram_wdata, add + mul * 64'(i));
            cyc();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input logic [63:0] exp_rdata);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (cpu_ready) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk({name, "_ready"}, 64'(ok), 64'd1);
        chk({name, "_rdata"}, cpu_rdata, exp_rdata);
        cyc();
    endtask

    // hit vectors against line 1 (0x8000_0040..0x8000_0078) once it is resident
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [5:0]  exp_ram_addr;
        logic [63:0] exp_rdata;
        logic [7:0]  exp_wena;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] wb_exp [8];
    logic        ok;

    initial begin
        vecs[0] = '{1'b0, 32'h8000_0048, 64'h0, 8'h00, 6'd9, 64'h22, 8'h00};
        vecs[1] = '{1'b1, 32'h8000_0048, 64'hDEADBEEF_CAFEF00D, 8'h0F, 6'd9, 64'h0, 8'h0F};
        vecs[2] = '{1'b0, 32'h8000_0048, 64'h0, 8'h00, 6'd9, 64'h00000000_CAFEF00D, 8'h00};
        vecs[3] = '{1'b0, 32'h8000_007C, 64'h0, 8'h00, 6'd15, 64'h88, 8'h00};
        vecs[4] = '{1'b1, 32'h8000_0050, 64'h11223344_55667788, 8'hF0, 6'd10, 64'h0, 8'hF0};
        vecs[5] = '{1'b0, 32'h8000_0050, 64'h0, 8'h00, 6'd10, 64'h11223344_00000033, 8'h00};
        wb_exp  = '{64'h11, 64'h00000000_CAFEF00D, 64'h11223344_00000033, 64'h44,
                    64'h55, 64'h66, 64'h77, 64'h88};

        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        mem_ack = 1'b0; mem_wready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_wvalid", 64'(mem_wvalid), 64'd0);
        chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
        chk("rst_ram_wena", 64'(ram_wena), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b1;
        cyc();

        // 1: cold load miss, clean fill, response from replay
        issue(1'b0, 32'h8000_0040, 64'h0, 8'h00, 6'd8);
        chk("t1_miss_no_ready", 64'(cpu_ready), 64'd0);
        wait_mem_req("t1_fill", 1'b0, 32'h8000_0040, 1'b1);
        fill_line(3'd1, 64'h11, 64'h11, 8);
        wait_ready("t1", 64'h11);
        chk("t1_no_writeback", 64'(wb_beats), 64'd0);

        // 2/3: hits, one access per two cycles
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].exp_ram_addr);
            chk("hit_ready", 64'(cpu_ready), 64'd1);
            chk("hit_rdata", cpu_rdata, vecs[v].exp_rdata);
            chk("hit_wena", 64'(ram_wena), 64'(vecs[v].exp_wena));
            chk("hit_ram_addr", 64'(ram_addr), 64'(vecs[v].exp_ram_addr));
            chk("hit_no_mem_req", 64'(mem_req), 64'd0);
            cyc();
            chk("hit_ready_pulse", 64'(cpu_ready), 64'd0);
            chk("hit_back_idle", 64'(dbg_state), 64'(S_IDLE));
        end

        // 4/5: conflicting load evicts dirty line 1; stall the writeback at beat 2
        issue(1'b0, 32'h8000_0240, 64'h0, 8'h00, 6'd8);
        wait_mem_req("t4_wb", 1'b1, 32'h8000_0040, 1'b1);
        for (int b = 0; b < 8; b++) begin
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (mem_wvalid) begin
                    ok = 1'b1;
                    break;
                end
                cyc();
            end
            chk("wb_valid_seen", 64'(ok), 64'd1);
            chk("wb_data", mem_wdata, wb_exp[b]);
            if (b == 2) begin
                for (int s = 0; s < 5; s++) begin
                    cyc();
                    chk("wb_stall_valid", 64'(mem_wvalid), 64'd1);
                    chk("wb_stall_data", mem_wdata, wb_exp[2]);
                    chk("wb_stall_state", 64'(dbg_state), 64'(S_WB_BEAT));
                end
            end
            mem_wready = 1'b1;
            cyc();
            mem_wready = 1'b0;
            #1;
        end
        chk("t4_wb_beats", 64'(wb_beats), 64'd8);
        wait_mem_req("t4_fill", 1'b0, 32'h8000_0240, 1'b1);
        fill_line(3'd1, 64'hA0, 64'h1, 8);
        wait_ready("t4", 64'hA0);

        // 6a: reset while a fill request is pending drops mem_req at once
        issue(1'b0, 32'h8000_0080, 64'h0, 8'h00, 6'd16);
        wait_mem_req("t6_req", 1'b0, 32'h8000_0080, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_req_async_drop", 64'(mem_req), 64'd0);
        chk("t6_req_state", 64'(dbg_state), 64'(S_IDLE));
        cyc();
        rst = 1'b1;
        cyc();

        // 6b: reset at fill beat 3
        issue(1'b0, 32'h8000_0080, 64'h0, 8'h00, 6'd16);
        wait_mem_req("t6_fill", 1'b0, 32'h8000_0080, 1'b1);
        fill_line(3'd2, 64'hB0, 64'h1, 3);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hB3;
        #1;
        chk("t6_beat3_wena", 64'(ram_wena), 64'hFF);
        rst = 1'b0;
        #1;
        chk("t6_rst_wena", 64'(ram_wena), 64'd0);
        chk("t6_rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("t6_rst_ready", 64'(cpu_ready), 64'd0);
        chk("t6_rst_state", 64'(dbg_state), 64'(S_IDLE));
        mem_rvalid = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // 6c: same address misses again and refetches without writeback
        issue(1'b0, 32'h8000_0080, 64'h0, 8'h00, 6'd16);
        chk("t6_remiss_no_ready", 64'(cpu_ready), 64'd0);
        wait_mem_req("t6_refetch", 1'b0, 32'h8000_0080, 1'b1);
        fill_line(3'd2, 64'hC0, 64'h1, 8);
        wait_ready("t6", 64'hC0);
        chk("t6_no_writeback", 64'(wb_beats), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
